kpn_arith_process: RTL and testbench



---
 rtl/kpn_pkg.sv | 16 +
 rtl/kpn_arith_process_if.sv | 46 ++++
 rtl/kpn_sat_alu.sv | 35 +++
 rtl/kpn_arith_process.sv | 109 ++++++++++
 tb/tb_kpn_arith_process.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN process nodes: FSM states, operation codes
// and the default token width used by the network FIFOs.
package kpn_pkg;

  localparam int KPN_DEFAULT_WIDTH = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } kpn_state_e;

endpackage

// File: rtl/kpn_arith_process_if.sv
// FIFO-side handshake bundle of an arithmetic KPN process: two input FIFOs,
// one output FIFO and the per-token operation select.
interface kpn_arith_process_if #(
  parameter int WIDTH = kpn_pkg::KPN_DEFAULT_WIDTH
) ();
  import kpn_pkg::*;

  logic             op_sel;
  logic [WIDTH-1:0] in1_data;
  logic             in1_empty;
  logic             in1_rd;
  logic [WIDTH-1:0] in2_data;
  logic             in2_empty;
  logic             in2_rd;
  logic [WIDTH-1:0] out_data;
  logic             out_full;
  logic             out_wr;

  // The process side pops the inputs and pushes the output.
  modport master (
    input  op_sel,
    input  in1_data,
    input  in1_empty,
    output in1_rd,
    input  in2_data,
    input  in2_empty,
    output in2_rd,
    output out_data,
    input  out_full,
    output out_wr
  );

  modport slave (
    output op_sel,
    output in1_data,
    output in1_empty,
    input  in1_rd,
    output in2_data,
    output in2_empty,
    input  in2_rd,
    input  out_data,
    output out_full,
    input  out_wr
  );

endinterface

// File: rtl/kpn_sat_alu.sv
// Combinational add/subtract on unsigned tokens with optional saturation;
// clip flags any carry out of an add or borrow out of a subtract.
module kpn_sat_alu
  import kpn_pkg::*;
#(
  parameter int WIDTH    = KPN_DEFAULT_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  output logic             clip
);

  logic [WIDTH:0] ext;

  // The extra top bit is the carry for add and the borrow for subtract.
  always_comb begin
    ext    = '0;
    result = '0;
    clip   = 1'b0;
    if (op == OP_ADD) begin
      ext = {1'b0, a} + {1'b0, b};
    end else begin
      ext = {1'b0, a} - {1'b0, b};
    end
    clip   = ext[WIDTH];
    result = ext[WIDTH-1:0];
    if ((SATURATE != 0) && clip) begin
      result = (op == OP_ADD) ? '1 : '0;
    end
  end

endmodule

// File: rtl/kpn_arith_process.sv
// Two-input, one-output Kahn process node: pops one token from each input
// FIFO, adds or subtracts them and blocks until the output FIFO accepts it.
module kpn_arith_process
  import kpn_pkg::*;
#(
  parameter int WIDTH     = KPN_DEFAULT_WIDTH,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  kpn_arith_process_if.master  fifo,
  output logic                 busy,
  output logic                 clipped,
  output logic [CNT_WIDTH-1:0] token_count
);

  kpn_state_e           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 op_q, op_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 clipped_q, clipped_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 rd_en;
  logic                 wr_en;
  logic [WIDTH-1:0]     alu_result;
  logic                 alu_clip;

  kpn_sat_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .clip   (alu_clip)
  );

  // Tokens are only ever popped as a pair so the two streams stay aligned.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    out_data_d = out_data_q;
    clipped_d  = clipped_q;
    count_d    = count_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo.in1_empty && !fifo.in2_empty) begin
          rd_en   = 1'b1;
          a_d     = fifo.in1_data;
          b_d     = fifo.in2_data;
          op_d    = fifo.op_sel;
          state_d = READ;
        end
      end
      READ: begin
        out_data_d = alu_result;
        clipped_d  = clipped_q | alu_clip;
        state_d    = WRITE;
      end
      WRITE: begin
        if (!fifo.out_full) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      out_data_q <= '0;
      clipped_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      out_data_q <= out_data_d;
      clipped_q  <= clipped_d;
      count_q    <= count_d;
    end
  end

  // Reset gates the strobes so they drop the instant reset rises.
  assign fifo.in1_rd   = rd_en & ~reset;
  assign fifo.in2_rd   = rd_en & ~reset;
  assign fifo.out_wr   = wr_en & ~reset;
  assign fifo.out_data = out_data_q;
  assign busy          = (state_q != IDLE);
  assign clipped       = clipped_q;
  assign token_count   = count_q;

endmodule

// File: tb/tb_kpn_arith_process.sv
// Bench for kpn_arith_process: a wrapping and a saturating instance run in
// lockstep behind modelled FIFOs, checked against an arithmetic reference.
module tb_kpn_arith_process;
  import kpn_pkg::*;

  localparam int W  = 16;
  localparam int CW = 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic         op;
  } tok1_t;

  typedef struct packed {
    logic [W-1:0] wrap_v;
    logic [W-1:0] sat_v;
    logic         clip;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] exp_wrap;
    logic [W-1:0] exp_sat;
    logic         exp_clip;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          busy_w, clipped_w, busy_s, clipped_s;
  logic [CW-1:0] count_w, count_s;

  kpn_arith_process_if #(.WIDTH(W)) if_w ();
  kpn_arith_process_if #(.WIDTH(W)) if_s ();

  kpn_arith_process #(.WIDTH(W), .SATURATE(0), .CNT_WIDTH(CW)) u_wrap (
    .clk(clk), .reset(reset), .fifo(if_w),
    .busy(busy_w), .clipped(clipped_w), .token_count(count_w)
  );

  kpn_arith_process #(.WIDTH(W), .SATURATE(1), .CNT_WIDTH(CW)) u_sat (
    .clk(clk), .reset(reset), .fifo(if_s),
    .busy(busy_s), .clipped(clipped_s), .token_count(count_s)
  );

  always #5 clk = ~clk;

  tok1_t        q1[$];
  logic [W-1:0] q2[$];
  exp_t         exp_q[$];
  logic         full_ctl = 1'b0;
  logic         busy_seen = 1'b0;
  int           cyc = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  int           last_rd_cyc = -1;
  int           last_wr_cyc = -1;
  int           tests = 0;
  int           fails = 0;

  logic [3:0]   s_rd;
  logic [1:0]   s_wr;
  logic [W-1:0] s_dw, s_ds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    exp_t e;
    int unsigned sa = a;
    int unsigned sb = b;
    int unsigned r;
    if (op == OP_ADD) begin
      r        = sa + sb;
      e.clip   = (r > 65535);
      e.wrap_v = W'(r % 65536);
      e.sat_v  = e.clip ? 16'hFFFF : W'(r);
    end else begin
      e.clip   = (sa < sb);
      e.wrap_v = W'((sa + 65536 - sb) % 65536);
      e.sat_v  = e.clip ? 16'h0000 : W'(sa - sb);
    end
    return e;
  endfunction

  // FIFO models: present heads at negedge, pop/push on the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        if_w.in1_empty = 1'b0;
        if_w.in1_data  = q1[0].a;
        if_w.op_sel    = q1[0].op;
      end else begin
        if_w.in1_empty = 1'b1;
        if_w.in1_data  = W'($urandom);
        if_w.op_sel    = 1'($urandom);
      end
      if (q2.size() > 0) begin
        if_w.in2_empty = 1'b0;
        if_w.in2_data  = q2[0];
      end else begin
        if_w.in2_empty = 1'b1;
        if_w.in2_data  = W'($urandom);
      end
      if_w.out_full  = full_ctl;
      if_s.in1_empty = if_w.in1_empty;
      if_s.in1_data  = if_w.in1_data;
      if_s.op_sel    = if_w.op_sel;
      if_s.in2_empty = if_w.in2_empty;
      if_s.in2_data  = if_w.in2_data;
      if_s.out_full  = if_w.out_full;
      #1;
      s_rd = {if_w.in1_rd, if_w.in2_rd, if_s.in1_rd, if_s.in2_rd};
      s_wr = {if_w.out_wr, if_s.out_wr};
      s_dw = if_w.out_data;
      s_ds = if_s.out_data;
      if (busy_w) busy_seen = 1'b1;
      if (s_rd != 4'h0) check("rd_pair", 32'(s_rd), 32'hF);
      if (s_wr != 2'b00) begin
        check("wr_pair", 32'(s_wr), 32'h3);
        check("wr_when_full", 32'(full_ctl), 32'h0);
      end
      @(posedge clk);
      cyc++;
      if (s_rd == 4'hF) begin
        rd_cnt++;
        last_rd_cyc = cyc;
        if (q1.size() > 0 && q2.size() > 0) begin
          void'(q1.pop_front());
          void'(q2.pop_front());
        end else begin
          check("rd_on_empty", 32'h1, 32'h0);
        end
      end
      if (s_wr == 2'b11) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_wrap", 32'(s_dw), 32'(e.wrap_v));
          check("data_sat", 32'(s_ds), 32'(e.sat_v));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    q1.push_back('{a: a, op: op});
    q2.push_back(b);
    exp_q.push_back(model(a, b, op));
  endtask

  task automatic wait_rd(input string name, input int target, input int budget);
    int k = 0;
    while (rd_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(rd_cnt), 32'(target));
  endtask

  task automatic wait_wr(input string name, input int target, input int budget);
    int k = 0;
    while (wr_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(wr_cnt), 32'(target));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   rd0, wr0, wr_a, cnt_model;
    logic clip_model;
    exp_t ea;

    vecs[0] = '{16'h0003, 16'h0005, OP_ADD, 16'h0008, 16'h0008, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0002, OP_ADD, 16'h0001, 16'hFFFF, 1'b1};
    vecs[2] = '{16'h0003, 16'h0005, OP_SUB, 16'hFFFE, 16'h0000, 1'b1};
    vecs[3] = '{16'h0010, 16'h0003, OP_SUB, 16'h000D, 16'h000D, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, OP_ADD, 16'h0000, 16'hFFFF, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0000, OP_ADD, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, OP_SUB, 16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{16'h0000, 16'hFFFF, OP_SUB, 16'h0001, 16'h0000, 1'b1};

    reset = 1'b1;
    repeat (3) tick();
    check("rst_out_data", {if_w.out_data, if_s.out_data}, 32'h0);
    check("rst_flags", {24'h0, busy_w, clipped_w, busy_s, clipped_s,
                        if_w.in1_rd, if_w.in2_rd, if_w.out_wr, if_s.out_wr}, 32'h0);
    check("rst_count", {count_w, count_s}, 32'h0);
    reset = 1'b0;
    tick();

    // Single token: paired read, write two cycles later.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    push_pair(16'd3, 16'd5, OP_ADD);
    wait_wr("t1_wr", wr0 + 1, 20);
    check("t1_rd_once", 32'(rd_cnt - rd0), 32'd1);
    check("t1_latency", 32'(last_wr_cyc - last_rd_cyc), 32'd2);
    check("t1_data", 32'(if_w.out_data), 32'd8);
    check("t1_count", 32'(count_w), 32'd1);
    check("t1_clipped", 32'(clipped_w), 32'd0);
    cnt_model  = 1;
    clip_model = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wr0 = wr_cnt;
      push_pair(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_wr("tbl_wr", wr0 + 1, 20);
      cnt_model++;
      clip_model = clip_model | vecs[i].exp_clip;
      check("tbl_wrap", 32'(if_w.out_data), 32'(vecs[i].exp_wrap));
      check("tbl_sat", 32'(if_s.out_data), 32'(vecs[i].exp_sat));
      check("tbl_count", {count_w, count_s}, {CW'(cnt_model), CW'(cnt_model)});
      check("tbl_clipped", {clipped_w, clipped_s}, {clip_model, clip_model});
    end

    // Only one input non-empty: nothing may be read.
    tick();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    busy_seen = 1'b0;
    q1.push_back('{a: 16'h0042, op: OP_ADD});
    repeat (10) tick();
    check("t4_no_rd", 32'(rd_cnt - rd0), 32'd0);
    check("t4_busy_low", {31'h0, busy_seen}, 32'd0);
    q2.push_back(16'h0007);
    exp_q.push_back(model(16'h0042, 16'h0007, OP_ADD));
    wait_wr("t4_wr", wr0 + 1, 20);
    check("t4_rd_once", 32'(rd_cnt - rd0), 32'd1);
    cnt_model++;

    // Output full: hold the token, stall reads, then write exactly once.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    full_ctl = 1'b1;
    ea = model(16'h1000, 16'h0234, OP_ADD);
    push_pair(16'h1000, 16'h0234, OP_ADD);
    push_pair(16'h0010, 16'h0020, OP_SUB);
    wait_rd("t5_rd", rd0 + 1, 20);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      check("t5_hold_w", 32'(if_w.out_data), 32'(ea.wrap_v));
      check("t5_hold_s", 32'(if_s.out_data), 32'(ea.sat_v));
      tick();
    end
    check("t5_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("t5_no_rd", 32'(rd_cnt - rd0), 32'd1);
    full_ctl = 1'b0;
    wait_wr("t5_wr", wr0 + 1, 10);
    wr_a = last_wr_cyc;
    tick();
    check("t5_next_rd_cyc", 32'(last_rd_cyc - wr_a), 32'd1);
    tick();
    check("t5_one_wr", 32'(wr_cnt - wr0), 32'd1);
    wait_wr("t5_wr_b", wr0 + 2, 20);
    cnt_model += 2;
    clip_model = 1'b1;
    check("t5_count", 32'(count_w), 32'(cnt_model));

    // Reset with a token in flight: it is discarded.
    rd0 = rd_cnt;
    push_pair(16'h0101, 16'h0202, OP_ADD);
    wait_rd("t6_rd", rd0 + 1, 20);
    tick();
    reset = 1'b1;
    #1;
    check("t6_rst_out_data", {if_w.out_data, if_s.out_data}, 32'h0);
    check("t6_rst_flags", {24'h0, busy_w, clipped_w, busy_s, clipped_s,
                           if_w.in1_rd, if_w.in2_rd, if_w.out_wr, if_s.out_wr}, 32'h0);
    check("t6_rst_count", {count_w, count_s}, 32'h0);
    exp_q.delete();
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    push_pair(16'h0500, 16'h0100, OP_SUB);
    repeat (3) tick();
    check("t6_no_rd_in_rst", 32'(rd_cnt - rd0), 32'd0);
    check("t6_no_wr_in_rst", 32'(wr_cnt - wr0), 32'd0);
    reset = 1'b0;
    wait_wr("t6_wr", wr0 + 1, 20);
    tick();
    check("t6_one_wr", 32'(wr_cnt - wr0), 32'd1);
    check("t6_count", {count_w, count_s}, {CW'(1), CW'(1)});
    check("t6_clipped", {30'h0, clipped_w, clipped_s}, 32'h0);
    cnt_model  = 1;
    clip_model = 1'b0;

    // Random traffic with random output back-pressure.
    begin
      int pushed = 0;
      int k = 0;
      wr0 = wr_cnt;
      while ((wr_cnt - wr0) < 40 && k < 4000) begin
        if (pushed < 40 && $urandom_range(0, 2) != 0) begin
          logic [W-1:0] ra, rb;
          logic         rop;
          exp_t         re;
          ra  = pick();
          rb  = pick();
          rop = 1'($urandom);
          re  = model(ra, rb, rop);
          clip_model = clip_model | re.clip;
          push_pair(ra, rb, rop);
          pushed++;
        end
        full_ctl = ($urandom_range(0, 3) == 0);
        tick();
        k++;
      end
      full_ctl = 1'b0;
      repeat (4) tick();
      check("rnd_wr_total", 32'(wr_cnt - wr0), 32'd40);
      check("rnd_exp_drained", 32'(exp_q.size()), 32'd0);
      cnt_model += 40;
      check("rnd_count", {count_w, count_s}, {CW'(cnt_model), CW'(cnt_model)});
      check("rnd_clipped", {clipped_w, clipped_s}, {clip_model, clip_model});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
